// File: rtl/sipo_shift_register_4b.sv
// Serial-in, parallel-out shift register; new bits enter at the MSB and q_bar mirrors ~q.
// Optional saturating fill counter and `full` flag when SIPO_FULL_FLAG_EN is defined.
module sipo_shift_register_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
`ifdef SIPO_FULL_FLAG_EN
  ,
  output logic             full
`endif
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (en) begin
      shift_d = {din, shift_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q = shift_q;

  // Complement is taken straight off the register so it can never lag q.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_qbar
      assign q_bar[gi] = ~shift_q[gi];
    end
  endgenerate

`ifdef SIPO_FULL_FLAG_EN
  localparam int              CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full_q;
  logic             full_d;

  // Counter saturates at WIDTH: once every bit holds shifted data it stays full.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    full_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign full = full_q;
`endif

endmodule

// File: tb/tb_sipo_shift_register_4b.sv
// Self-checking bench: directed test-plan scenarios with literal expectations, then random
// stimulus checked every cycle against a bit-history model of the register.
module tb_sipo_shift_register_4b;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic             din = 1'b0;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             full_obs;

`ifdef SIPO_FULL_FLAG_EN
  logic full;
  assign full_obs = full;
`endif

  sipo_shift_register_4b #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .din   (din),
    .q     (q),
    .q_bar (q_bar)
`ifdef SIPO_FULL_FLAG_EN
    ,
    .full  (full)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model: the most recent enabled bits since reset, oldest first, capped at WIDTH.
  bit hist[$];
  bit model_valid = 1'b0;

  function automatic logic [WIDTH-1:0] model_q();
    logic [WIDTH-1:0] v;
    int n;
    v = '0;
    n = hist.size();
    for (int k = 0; k < n; k++) v[WIDTH - n + k] = hist[k];
    return v;
  endfunction

  function automatic logic model_full();
    return hist.size() == WIDTH;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b required %b (t=%0t)", name, got, exp, $time);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      model_valid = 1'b1;
    end else if (en) begin
      hist.push_back(din);
      if (hist.size() > WIDTH) void'(hist.pop_front());
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_q", q, model_q());
      check("model_q_bar", q_bar, ~model_q());
`ifdef SIPO_FULL_FLAG_EN
      check("model_full", {3'b000, full_obs}, {3'b000, model_full()});
`endif
    end
  end

  task automatic step(input logic r, input logic e, input logic d);
    @(negedge clk);
    rst = r;
    en  = e;
    din = d;
    @(posedge clk);
    #1;
    $display("step rst=%b en=%b din=%b -> q=%b q_bar=%b", r, e, d, q, q_bar);
  endtask

  task automatic lit(input string name, input logic [WIDTH-1:0] exp_q, input logic exp_full);
    check({name, "_q"}, q, exp_q);
    check({name, "_q_bar"}, q_bar, ~exp_q);
`ifdef SIPO_FULL_FLAG_EN
    check({name, "_full"}, {3'b000, full_obs}, {3'b000, exp_full});
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] fill_exp [4];
    bit               fill_din [4];
    fill_exp = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
    fill_din = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Reset with en/din high
    step(1'b1, 1'b1, 1'b1);
    lit("reset", 4'b0000, 1'b0);

    // Serial fill
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, fill_din[i]);
      lit("fill", fill_exp[i], i == 3);
    end
    check("fill_q_bar_lit", q_bar, 4'b0010);

    // Hold with din toggling
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, i[0]);
      lit("hold", 4'b1101, 1'b1);
    end

    // Overflow with zeros
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    lit("overflow", 4'b0000, 1'b1);

    // Mid-stream reset
    step(1'b1, 1'b0, 1'b0);
    lit("mid_rst0", 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    lit("mid_two", 4'b1100, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    lit("mid_rst", 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    lit("mid_after", 4'b1000, 1'b0);

    // Reset priority over enable
    step(1'b1, 1'b1, 1'b1);
    lit("rst_prio", 4'b0000, 1'b0);

    // Randomized stimulus, checked each cycle by the compare process
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 1));
      // Mid-cycle input wiggle must not matter
      #2 din = ~din;
      en = ~en;
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sipo_shift_register_4b.md
# sipo_shift_register_4b

4-bit serial-in, parallel-out shift register with complementary parallel outputs. One serial bit is captured on each enabled rising clock edge, and the four most recent bits appear on `q` and on its complement `q_bar`. It sits at the edge of a serial datapath, for example a deserialiser front end or a bit-stream capture stage, and feeds downstream parallel logic.

## Interface
Parameters:
- `WIDTH`, default 4: register length in bits. The module is verified at 4 only; other values are structurally allowed.

Ports:
- `clk`  input  1  rising-edge clock; all state changes on this edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  shift enable; a shift occurs only when high.
- `din`  input  1  serial data in.
- `q`  output  WIDTH  parallel register contents.
- `q_bar`  output  WIDTH  bitwise complement of `q`.
- `full`  output  1  present only when `SIPO_FULL_FLAG_EN` is defined; high once WIDTH bits have been shifted since reset.

## Operation
- Shift direction is right, with new data entering at the MSB.
- On each enabled edge: `q <= {din, q[WIDTH-1:1]}`.
- `q[WIDTH-1]` is always the newest bit; `q[0]` is the oldest retained bit.
- The bit previously in `q[0]` is discarded.
- When `en` = 0, `q` holds its value, and any fill counter also holds.
- `q_bar` is always `~q`.
  - `q_bar` is combinational from the `q` register, not a separate flop.
  - `q_bar` can never be out of step with `q`.
- Reset:
  - `rst` = 1 at a rising edge forces `q` = 0000, and therefore `q_bar` = 1111.
  - Reset has priority over `en` and `din`.
  - Reset asserted mid-stream discards all partially shifted data.
- No state exists beyond `q` and, when configured, the fill counter.
- Outputs are X-free only after the first reset edge; the bench must apply reset before checking values.

## Timing
- Latency: a bit presented on `din` at rising edge N appears on `q[WIDTH-1]` immediately after edge N.
  - The same bit reaches `q[0]` after edge N+WIDTH-1.
  - The bit is shifted out at edge N+WIDTH.
- `din` and `en` must meet setup/hold around the rising edge. Changing them mid-cycle, away from the edge, has no effect.
- Simultaneous `rst` = 1 and `en` = 1 results in reset: `q` = 0, and the counter is cleared.
- `q_bar` settles combinationally in the same cycle that `q` updates.

## Configuration
- Macro `SIPO_FULL_FLAG_EN`.
- Defined:
  - Adds a saturating shift counter, range 0..WIDTH, cleared by `rst`.
  - The counter increments on each enabled edge until it reaches WIDTH, then holds.
  - `full` = 1 when the counter equals WIDTH. This means every bit of `q` holds shifted data rather than reset value.
  - `full` is registered and rises after the WIDTH-th enabled edge following reset.
  - `full` stays high until the next reset; disabled cycles do not clear it.
- Not defined:
  - No counter and no `full` port.
  - Shift behaviour is otherwise identical.

## Test plan
- **Reset:** `rst` = 1 for one edge with `en` = 1, `din` = 1 → `q` = 0000, `q_bar` = 1111. With the macro, `full` = 0.
- **Serial fill:** after reset, `en` = 1, `din` = 1, 0, 1, 1 on four consecutive edges.
  - Expected `q` after each edge: 1000, 0100, 1010, 1101.
  - `q_bar` = 0010 at the end.
  - With the macro, `full` = 1 only after the 4th edge.
- **Hold:** from `q` = 1101, `en` = 0 for 3 edges with `din` toggling → `q` stays 1101 and `q_bar` stays 0010.
- **Overflow:** from `q` = 1101, `en` = 1, `din` = 0 for 4 edges → `q` = 0000 and `q_bar` = 1111. With the macro, `full` stays 1.
- **Mid-stream reset:** after 2 enabled shifts of `din` = 1 (`q` = 1100), `rst` = 1 on the next edge → `q` = 0000.
  - Afterwards, one enabled shift of `din` = 1 → `q` = 1000.
  - With the macro, `full` = 0 throughout this scenario.
- **Reset priority:** `rst` = 1 and `en` = 1 with `din` = 1 on the same edge → `q` = 0000, not 1000.
